// File: rtl/pipe_seq_pkg.sv
// pipe_seq_pkg: shared state encoding for the frame sequencer and its watchdog.
package pipe_seq_pkg;
    localparam int STATE_W = 3;
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_SOF = 3'd1,
        ST_FLUSH    = 3'd2,
        ST_ARM      = 3'd3,
        ST_RUN      = 3'd4
    } state_t;
endpackage

// File: rtl/pipe_seq_wdog.sv
// pipe_seq_wdog: RUN-state idle counter; o_expire marks the WDOG_CYCLES-th consecutive idle cycle.
// Only compiled when PIPE_WDOG_EN is defined.
`ifdef PIPE_WDOG_EN
module pipe_seq_wdog #(
    parameter int WDOG_CYCLES = 4096
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_active,
    input  logic i_pix_rd,
    output logic o_expire
);
    localparam int W = $clog2(WDOG_CYCLES + 1);
    logic [W-1:0] cnt;
    logic idle;
    assign idle = i_active && !i_pix_rd;
    assign o_expire = idle && (cnt == W'(WDOG_CYCLES - 1));
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) cnt <= '0;
        else cnt <= (idle && !o_expire) ? cnt + W'(1) : '0;
    end
endmodule
`endif

// File: rtl/pipe_frame_sequencer.sv
// pipe_frame_sequencer: aligns the pixel pipeline to camera SOF, flushes it and re-syncs on bad frames.
// Define PIPE_WDOG_EN to add the stalled-stream watchdog re-sync.
module pipe_frame_sequencer
    import pipe_seq_pkg::*;
#(
    parameter int FRAME_PIXELS = 307200,
    parameter int FLUSH_CYCLES = 8,
    parameter int WDOG_CYCLES  = 4096,
    parameter int CNT_W        = 19
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_enable,
    input  logic         i_cam_sof,
    input  logic         i_pix_rd,
    output logic         o_flush,
    output logic         o_pipe_en,
    output logic [2:0]   o_state,
    output logic [7:0]   o_frame_cnt,
    output logic         o_resync,
    output logic         o_err_len
);
    localparam int FW = $clog2(FLUSH_CYCLES) + 1;
    localparam logic [CNT_W-1:0] FP = CNT_W'(FRAME_PIXELS);
    localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES - 1);
    state_t state, state_nx;
    logic [FW-1:0] fcnt, fcnt_nx;
    logic [CNT_W-1:0] pix_cnt, pix_cnt_nx, pix_inc;
    logic [7:0] frame_nx;
    logic resync_nx, err_nx, rd, over, wdog_exp;
    assign rd = o_pipe_en && i_pix_rd;
    assign pix_inc = (&pix_cnt) ? pix_cnt : pix_cnt + CNT_W'(rd);
    assign over = rd && (pix_cnt >= FP);
    assign o_state = state;
`ifdef PIPE_WDOG_EN
    pipe_seq_wdog #(.WDOG_CYCLES(WDOG_CYCLES)) u_wdog (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_active (state == ST_RUN),
        .i_pix_rd (rd),
        .o_expire (wdog_exp)
    );
`else
    assign wdog_exp = 1'b0;
`endif
    always_comb begin
        state_nx   = state;
        fcnt_nx    = fcnt;
        pix_cnt_nx = pix_cnt;
        frame_nx   = o_frame_cnt;
        resync_nx  = 1'b0;
        err_nx     = o_err_len;
        if (!i_enable) state_nx = ST_IDLE;
        else case (state)
            ST_IDLE: state_nx = ST_WAIT_SOF;
            ST_WAIT_SOF: if (i_cam_sof) begin
                state_nx = ST_FLUSH;
                fcnt_nx  = FLUSH_LOAD;
            end
            ST_FLUSH: if (fcnt == '0) state_nx = ST_ARM;
                      else fcnt_nx = fcnt - FW'(1);
            ST_ARM: begin
                pix_cnt_nx = '0;
                state_nx   = ST_RUN;
            end
            ST_RUN: begin
                // SOF length check outranks overrun and watchdog; a bad SOF is itself the new alignment point
                if (i_cam_sof) begin
                    if (pix_cnt == FP) begin
                        frame_nx   = o_frame_cnt + 8'd1;
                        pix_cnt_nx = CNT_W'(rd);
                    end else begin
                        err_nx    = 1'b1;
                        resync_nx = 1'b1;
                        state_nx  = ST_FLUSH;
                        fcnt_nx   = FLUSH_LOAD;
                    end
                end else if (over) begin
                    err_nx    = 1'b1;
                    resync_nx = 1'b1;
                    state_nx  = ST_WAIT_SOF;
                end else if (wdog_exp) begin
                    resync_nx = 1'b1;
                    state_nx  = ST_WAIT_SOF;
                end else pix_cnt_nx = pix_inc;
            end
            default: state_nx = ST_IDLE;
        endcase
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            fcnt        <= '0;
            pix_cnt     <= '0;
            o_flush     <= 1'b0;
            o_pipe_en   <= 1'b0;
            o_frame_cnt <= '0;
            o_resync    <= 1'b0;
            o_err_len   <= 1'b0;
        end else begin
            state       <= state_nx;
            fcnt        <= fcnt_nx;
            pix_cnt     <= pix_cnt_nx;
            o_flush     <= (state_nx == ST_FLUSH);
            o_pipe_en   <= (state_nx == ST_RUN);
            o_frame_cnt <= frame_nx;
            o_resync    <= resync_nx;
            o_err_len   <= err_nx;
        end
    end
endmodule
